wb_regs: RTL and testbench

WB_REGS -- requirements
Module: wb_regs

---
 rtl/wb_regs.sv | 82 ++++++++
 tb/tb_wb_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regs.sv
// wb_regs: 32 x 32-bit register file with a writeback stage, a commit counter and
// optional read forwarding enabled by the macro WB_REGS_BYPASS_EN.
module wb_regs (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rd_addr_i,
   input  logic [31:0] rd_data_i,
   input  logic        rd_wr_en_i,
   input  logic        hold_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o,
   input  logic [4:0]  dbg_addr_i,
   output logic [31:0] dbg_data_o,
   output logic [31:0] wr_cnt_o
);

   logic [31:0] regs_reg [32];
   logic [4:0]  wb_addr_reg;
   logic [31:0] wb_data_reg;
   logic        wb_en_reg;
   logic [31:0] wr_cnt_reg;
   logic        commit;

   // x0 is never written, so commits to it are also not counted.
   assign commit = wb_en_reg && (wb_addr_reg != 5'd0);

   // Hold only blocks capture: the pending writeback still commits on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_addr_reg <= '0;
         wb_data_reg <= '0;
         wb_en_reg   <= 1'b0;
         wr_cnt_reg  <= '0;
      end else begin
         wb_en_reg <= rd_wr_en_i && !hold_i;
         if (!hold_i) begin
            wb_addr_reg <= rd_addr_i;
            wb_data_reg <= rd_data_i;
         end
         if (commit) begin
            wr_cnt_reg <= wr_cnt_reg + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (commit) begin
         regs_reg[wb_addr_reg] <= wb_data_reg;
      end
   end

   // Newest data wins: execute stage, then writeback stage, then the array.
   function automatic logic [31:0] read_port(input logic [4:0] addr);
      if (addr == 5'd0) begin
         return 32'd0;
      end
`ifdef WB_REGS_BYPASS_EN
      if (rd_wr_en_i && (rd_addr_i == addr)) begin
         return rd_data_i;
      end
      if (wb_en_reg && (wb_addr_reg == addr)) begin
         return wb_data_reg;
      end
`endif
      return regs_reg[addr];
   endfunction

   always_comb begin
      rs1_data_o = read_port(rs1_addr_i);
      rs2_data_o = read_port(rs2_addr_i);
      dbg_data_o = (dbg_addr_i == 5'd0) ? 32'd0 : regs_reg[dbg_addr_i];
   end

   assign wr_cnt_o = wr_cnt_reg;

endmodule

// File: tb/tb_wb_regs.sv
// tb_wb_regs: vector table, hand-written reset/wrap sequences and a randomized
// scoreboard phase for wb_regs; expectations follow WB_REGS_BYPASS_EN if defined.
module tb_wb_regs;

   logic        clk;
   logic        rst;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        we;
   logic        hold;
   logic [4:0]  r1;
   logic [4:0]  r2;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  da;
   logic [31:0] dbg_data;
   logic [31:0] wr_cnt;

   int n_checks = 0;
   int n_errors = 0;

`ifdef WB_REGS_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_regs dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr_i  (wa),
      .rd_data_i  (wd),
      .rd_wr_en_i (we),
      .hold_i     (hold),
      .rs1_addr_i (r1),
      .rs2_addr_i (r2),
      .rs1_data_o (rs1_data),
      .rs2_data_o (rs2_data),
      .dbg_addr_i (da),
      .dbg_data_o (dbg_data),
      .wr_cnt_o   (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: array, commit counter and a scoreboard of captured writebacks.
   typedef struct packed {
      logic        valid;
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   logic [31:0] m_rf [32];
   logic [31:0] m_cnt;
   wb_t         sb [$];

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        we;
      logic        hold;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  da;
      logic [31:0] e1b;
      logic [31:0] e1n;
      logic [31:0] e2b;
      logic [31:0] e2n;
      logic [31:0] edbg;
      logic [31:0] ecnt;
   } vec_t;

   vec_t vecs [23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_rf[i] = 32'd0;
      end
      m_cnt = 32'd0;
      sb.delete();
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) begin
         return 32'd0;
      end
      if (BYP) begin
         if (we && (wa == a)) begin
            return wd;
         end
         if ((sb.size() > 0) && sb[0].valid && (sb[0].addr == a)) begin
            return sb[0].data;
         end
      end
      return m_rf[a];
   endfunction

   // One rising edge: retire the oldest scoreboard entry, then record the new capture.
   task automatic tick();
      wb_t e;
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.valid && (e.addr != 5'd0)) begin
               m_rf[e.addr] = e.data;
               m_cnt        = m_cnt + 32'd1;
            end
         end
         e.valid = we && !hold;
         e.addr  = wa;
         e.data  = wd;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [4:0] a, input logic [31:0] d, input logic w,
                        input logic h, input logic [4:0] p1, input logic [4:0] p2,
                        input logic [4:0] pd);
      wa   = a;
      wd   = d;
      we   = w;
      hold = h;
      r1   = p1;
      r2   = p2;
      da   = pd;
   endtask

   initial begin
      // wa, wd, we, hold, r1, r2, da, rs1 (byp, no-byp), rs2 (byp, no-byp), dbg, cnt
      vecs[0]  = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd5,  5'd0,  5'd5,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'd0};
      vecs[1]  = '{5'd5,  32'h1234_5678, 1'b1, 1'b0, 5'd5,  5'd6,  5'd5,  32'h1234_5678, 32'h0,         32'h0,         32'h0,         32'h0,         32'd0};
      vecs[2]  = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd5,  5'd5,  5'd5,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0,         32'h0,         32'd0};
      vecs[3]  = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd5,  5'd0,  5'd5,  32'h1234_5678, 32'h1234_5678, 32'h0,         32'h0,         32'h1234_5678, 32'd1};
      vecs[4]  = '{5'd7,  32'hDEAD_BEEF, 1'b1, 1'b0, 5'd7,  5'd7,  5'd7,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0,         32'd1};
      vecs[5]  = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd7,  5'd7,  5'd7,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0,         32'd1};
      vecs[6]  = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd7,  5'd5,  5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF, 32'd2};
      vecs[7]  = '{5'd0,  32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'd2};
      vecs[8]  = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'd2};
      vecs[9]  = '{5'd3,  32'h11,        1'b1, 1'b1, 5'd3,  5'd0,  5'd3,  32'h11,        32'h0,         32'h0,         32'h0,         32'h0,         32'd2};
      vecs[10] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd3,  5'd3,  5'd3,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'd2};
      vecs[11] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd3,  5'd3,  5'd3,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'd2};
      vecs[12] = '{5'd9,  32'hA,         1'b1, 1'b0, 5'd9,  5'd9,  5'd9,  32'hA,         32'h0,         32'hA,         32'h0,         32'h0,         32'd2};
      vecs[13] = '{5'd9,  32'hB,         1'b1, 1'b0, 5'd9,  5'd9,  5'd9,  32'hB,         32'h0,         32'hB,         32'h0,         32'h0,         32'd2};
      vecs[14] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd9,  5'd9,  5'd9,  32'hB,         32'hA,         32'hB,         32'hA,         32'hA,         32'd3};
      vecs[15] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd9,  5'd7,  5'd9,  32'hB,         32'hB,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hB,         32'd4};
      vecs[16] = '{5'd10, 32'h77,        1'b1, 1'b0, 5'd10, 5'd0,  5'd10, 32'h77,        32'h0,         32'h0,         32'h0,         32'h0,         32'd4};
      vecs[17] = '{5'd11, 32'h88,        1'b1, 1'b1, 5'd10, 5'd11, 5'd10, 32'h77,        32'h0,         32'h88,        32'h0,         32'h0,         32'd4};
      vecs[18] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd10, 5'd11, 5'd10, 32'h77,        32'h77,        32'h0,         32'h0,         32'h77,        32'd5};
      vecs[19] = '{5'd10, 32'h99,        1'b1, 1'b0, 5'd10, 5'd10, 5'd10, 32'h99,        32'h77,        32'h99,        32'h77,        32'h77,        32'd5};
      vecs[20] = '{5'd10, 32'hAA,        1'b1, 1'b0, 5'd10, 5'd10, 5'd10, 32'hAA,        32'h77,        32'hAA,        32'h77,        32'h77,        32'd5};
      vecs[21] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd10, 5'd0,  5'd10, 32'hAA,        32'h99,        32'h0,         32'h0,         32'h99,        32'd6};
      vecs[22] = '{5'd0,  32'h0,         1'b0, 1'b0, 5'd10, 5'd0,  5'd10, 32'hAA,        32'hAA,        32'h0,         32'h0,         32'hAA,        32'd7};

      rst = 1'b1;
      drive(5'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5);
      m_reset();
      @(negedge clk);
      #1;
      check("reset_rs1", rs1_data, 32'd0);
      check("reset_dbg", dbg_data, 32'd0);
      check("reset_cnt", wr_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table phase: combinational reads checked before each edge.
      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].wa, vecs[i].wd, vecs[i].we, vecs[i].hold, vecs[i].r1, vecs[i].r2, vecs[i].da);
         #1;
         $display("vec %0d: wa=%0d wd=%h we=%b hold=%b rs1=%h rs2=%h dbg=%h cnt=%0d",
                  i, wa, wd, we, hold, rs1_data, rs2_data, dbg_data, wr_cnt);
         check($sformatf("vec%0d_rs1", i), rs1_data, BYP ? vecs[i].e1b : vecs[i].e1n);
         check($sformatf("vec%0d_rs2", i), rs2_data, BYP ? vecs[i].e2b : vecs[i].e2n);
         check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].edbg);
         check($sformatf("vec%0d_cnt", i), wr_cnt, vecs[i].ecnt);
         tick();
      end

      // Reset asserted while x4=0x55 sits in the writeback stage.
      drive(5'd4, 32'h55, 1'b1, 1'b0, 5'd4, 5'd0, 5'd4);
      tick();
      drive(5'd4, 32'h66, 1'b1, 1'b0, 5'd4, 5'd0, 5'd4);
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      $display("reset asserted mid-cycle: dbg=%h cnt=%0d", dbg_data, wr_cnt);
      check("rst_async_cnt", wr_cnt, 32'd0);
      check("rst_async_dbg", dbg_data, 32'd0);
      tick();
      drive(5'd0, 32'd0, 1'b0, 1'b0, 5'd4, 5'd10, 5'd4);
      rst = 1'b0;
      tick();
      tick();
      #1;
      $display("after reset: rs1=%h rs2=%h dbg=%h cnt=%0d", rs1_data, rs2_data, dbg_data, wr_cnt);
      check("rst_x4_dbg", dbg_data, 32'd0);
      check("rst_x4_rs1", rs1_data, 32'd0);
      check("rst_x10_rs2", rs2_data, 32'd0);
      check("rst_cnt", wr_cnt, 32'd0);

      // Counter wrap: preload the counter, then commit one write.
      dut.wr_cnt_reg = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1;
      check("wrap_preload", wr_cnt, 32'hFFFF_FFFF);
      drive(5'd12, 32'h5, 1'b1, 1'b0, 5'd12, 5'd0, 5'd12);
      tick();
      drive(5'd0, 32'd0, 1'b0, 1'b0, 5'd12, 5'd0, 5'd12);
      tick();
      #1;
      $display("wrap: dbg=%h cnt=%h", dbg_data, wr_cnt);
      check("wrap_cnt", wr_cnt, 32'd0);
      check("wrap_dbg", dbg_data, 32'h5);

      // Randomized phase against the scoreboard model.
      for (int c = 0; c < 300; c++) begin
         logic [4:0] p1;
         p1 = 5'($urandom_range(0, 15));
         drive(5'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 3) == 0), p1,
               ($urandom_range(0, 3) == 0) ? p1 : 5'($urandom_range(0, 15)),
               5'($urandom_range(0, 15)));
         #1;
         $display("rnd %0d: wa=%0d wd=%h we=%b hold=%b r1=%0d r2=%0d da=%0d rs1=%h rs2=%h dbg=%h cnt=%0d",
                  c, wa, wd, we, hold, r1, r2, da, rs1_data, rs2_data, dbg_data, wr_cnt);
         check($sformatf("rnd%0d_rs1", c), rs1_data, m_read(r1));
         check($sformatf("rnd%0d_rs2", c), rs2_data, m_read(r2));
         check($sformatf("rnd%0d_dbg", c), dbg_data, (da == 5'd0) ? 32'd0 : m_rf[da]);
         check($sformatf("rnd%0d_cnt", c), wr_cnt, m_cnt);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
